// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared opcode/funct constants, class codes and types for the fetch stage
//
// Purpose: single source for the instruction encoding the pre-decoder
// recognises, the 4-bit class codes handed to decode, the fetch FSM state
// type and the packed entry type held by the ID slot and the skid buffer.
// Ports: none (package).

package fetch_stage_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes, instr[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Instruction class codes presented on id_class
  localparam logic [3:0] CLS_ADDU    = 4'h0;
  localparam logic [3:0] CLS_SUBU    = 4'h1;
  localparam logic [3:0] CLS_ORI     = 4'h2;
  localparam logic [3:0] CLS_LW      = 4'h3;
  localparam logic [3:0] CLS_SW      = 4'h4;
  localparam logic [3:0] CLS_BEQ     = 4'h5;
  localparam logic [3:0] CLS_LUI     = 4'h6;
  localparam logic [3:0] CLS_JAL     = 4'h7;
  localparam logic [3:0] CLS_JR      = 4'h8;
  localparam logic [3:0] CLS_SLL     = 4'h9;
  localparam logic [3:0] CLS_ILLEGAL = 4'hF;

  // IDLE: nothing outstanding; WAIT: read outstanding and wanted;
  // DROP: read outstanding but made stale by a redirect.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_RESET = '{instr: 32'h0, pc: 32'h0, cls: CLS_ILLEGAL};

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_classify.sv
// rtl/fetch_stage_classify.sv - combinational pre-decode of one instruction word into its class code
//
// Purpose: maps opcode[31:26] / funct[5:0] onto the 4-bit class code;
// every encoding not listed is ILLEGAL.
// Ports:
//   word  in  32  instruction word
//   cls   out 4   class code

module instr_classify
  import fetch_stage_pkg::*;
(
  input  logic [31:0] word,
  output logic [3:0]  cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = word[31:26];
  assign funct         = word[5:0];
  // Register/immediate fields play no part in classification.
  assign unused_fields = ^word[25:6];

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_SLL:  cls = CLS_SLL;   // all-zero nop lands here
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_LUI:  cls = CLS_LUI;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch and pre-decode stage with PC, imem handshake, skid buffer and ID slot
//
// Purpose: owns the PC, issues word reads over imem_req/imem_ack, classifies
// each returned word and presents {instr, pc, class} to decode through a
// valid/ready slot backed by a one-entry skid buffer. Redirects override
// everything; a read already in flight when a redirect lands is drained and
// thrown away (DROP state).
// Optional feature macro: FETCH_PERF_EN adds fetch/stall performance counters.
// Ports:
//   clk             in   1      rising-edge clock
//   reset_n         in   1      asynchronous active-low reset
//   imem_req        out  1      fetch request, held until imem_ack
//   imem_addr       out  32     word address of the request
//   imem_ack        in   1      read data valid this cycle
//   imem_rdata      in   32     instruction word
//   redirect_valid  in   1      taken branch/jump
//   redirect_pc     in   32     redirect target (low two bits ignored)
//   id_ready        in   1      decode consumes the slot this cycle
//   id_valid        out  1      slot holds an instruction
//   id_instr        out  32     slot instruction word
//   id_pc           out  32     slot instruction address
//   id_class        out  4      slot class code
//   perf_fetch_cnt  out  CNT_W  words accepted (FETCH_PERF_EN only)
//   perf_stall_cnt  out  CNT_W  cycles with id_valid && !id_ready (FETCH_PERF_EN only)

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [3:0]        id_class
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_fetch_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  fetch_entry_t slot_q, slot_d;
  logic         slot_valid_q, slot_valid_d;
  fetch_entry_t skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;

  logic [3:0]   rdata_cls;
  logic [31:0]  fetch_pc;
  fetch_entry_t new_entry;
  logic         capture;
  logic         slot_free;
  logic         req_raw;

  instr_classify u_classify (
    .word (imem_rdata),
    .cls  (rdata_cls)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    req_raw      = 1'b0;
    imem_addr    = req_addr_q;
    capture      = 1'b0;
    // In WAIT pc_q still equals req_addr_q; only DROP lets them diverge.
    fetch_pc     = (state_q == ST_IDLE) ? pc_q : req_addr_q;

    case (state_q)
      ST_IDLE: begin
        imem_addr = pc_q;
        // A full skid buffer means the slot is blocked too: stop fetching.
        if (!skid_valid_q && !redirect_valid) begin
          req_raw = 1'b1;
          if (imem_ack) begin
            capture = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            req_addr_d = pc_q;
          end
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          state_d = ST_IDLE;
          capture = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    new_entry = '{instr: imem_rdata, pc: fetch_pc, cls: rdata_cls};
    if (capture) begin
      pc_d = fetch_pc + 32'd4;
    end

    slot_free = !slot_valid_q || id_ready;

    if (redirect_valid) begin
      // Slot and skid are flushed; a consuming id_ready this cycle still
      // counts as having taken the slot.
      pc_d         = align_word(redirect_pc);
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        // Older skid word goes first; a same-cycle capture backfills the skid.
        slot_d       = skid_q;
        slot_valid_d = 1'b1;
        skid_valid_d = capture;
        if (capture) begin
          skid_d = new_entry;
        end
      end else if (capture) begin
        slot_d       = new_entry;
        slot_valid_d = 1'b1;
      end else begin
        slot_valid_d = 1'b0;
      end
    end else if (capture) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end

    imem_req = req_raw && reset_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      slot_q       <= ENTRY_RESET;
      slot_valid_q <= 1'b0;
      skid_q       <= ENTRY_RESET;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign id_valid = slot_valid_q;
  assign id_instr = slot_q.instr;
  assign id_pc    = slot_q.pc;
  assign id_class = slot_q.cls;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (capture) begin
      perf_fetch_cnt_d = perf_fetch_cnt_q + CNT_W'(1);
    end
    if (slot_valid_q && !id_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`else
  // Counter width only matters when the counters exist.
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a sequential-stream reference model

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [3:0]  id_class;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_class       (id_class)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          n_consumed;
  logic [31:0] ovr [logic [31:0]];

  // memory model state
  logic        pending;
  int          wcnt;
  int          force_lat;
  int          max_lat;

  // reference model: the decode stage must see a gapless word stream
  // starting at the last reset/redirect target
  logic [31:0] exp_pc;

  // per-cycle samples (taken just before the active edge)
  logic        c_req, c_ack, c_idv, prev_hold;
  logic [31:0] c_addr, c_pc, c_instr, prev_addr;
  logic [3:0]  c_cls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [31:0] w;
    if (ovr.exists(a)) return ovr[a];
    h = (a * 32'h9E37_79B1) ^ (a >> 5);
    case (h[31:28])
      4'd0:    w = {6'h00, h[19:0], 6'h21};
      4'd1:    w = {6'h00, h[19:0], 6'h23};
      4'd2:    w = {6'h00, h[19:0], 6'h00};
      4'd3:    w = {6'h00, h[19:0], 6'h08};
      4'd4:    w = 32'h0;
      4'd5:    w = {6'h0D, h[25:0]};
      4'd6:    w = {6'h23, h[25:0]};
      4'd7:    w = {6'h2B, h[25:0]};
      4'd8:    w = {6'h04, h[25:0]};
      4'd9:    w = {6'h0F, h[25:0]};
      4'd10:   w = {6'h03, h[25:0]};
      4'd11:   w = {6'h00, h[19:0], 6'h22};
      4'd12:   w = {6'h3F, h[25:0]};
      4'd13:   w = {6'h08, h[25:0]};
      4'd14:   w = {6'h00, h[19:0], 6'h2A};
      default: w = {6'h01, h[25:0]};
    endcase
    return w;
  endfunction

  function automatic logic [3:0] ref_class(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] c;
    op = w[31:26];
    fn = w[5:0];
    c  = 4'hF;
    if (op == 6'h00) begin
      if (fn == 6'h21) c = 4'd0;
      else if (fn == 6'h23) c = 4'd1;
      else if (fn == 6'h00) c = 4'd9;
      else if (fn == 6'h08) c = 4'd8;
    end else if (op == 6'h0D) c = 4'd2;
    else if (op == 6'h23) c = 4'd3;
    else if (op == 6'h2B) c = 4'd4;
    else if (op == 6'h04) c = 4'd5;
    else if (op == 6'h0F) c = 4'd6;
    else if (op == 6'h03) c = 4'd7;
    return c;
  endfunction

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    imem_ack       = 1'b0;
    imem_rdata     = $urandom;
    #1;
    if (reset_n && imem_req) begin
      if (!pending) begin
        pending = 1'b1;
        wcnt    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, max_lat));
      end
      if (wcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        pending    = 1'b0;
      end else begin
        wcnt--;
      end
    end
    #1;
    c_req   = imem_req;
    c_addr  = imem_addr;
    c_ack   = imem_ack;
    c_idv   = id_valid;
    c_pc    = id_pc;
    c_instr = id_instr;
    c_cls   = id_class;
    if (reset_n) begin
      if (prev_hold) begin
        check("req_hold", {31'b0, imem_req}, 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end
      if (id_valid && id_ready) begin
        check("stream_pc", id_pc, exp_pc);
        check("stream_instr", id_instr, mem_word(exp_pc));
        check("stream_class", {28'b0, id_class}, {28'b0, ref_class(mem_word(exp_pc))});
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (rv) exp_pc = {rpc[31:2], 2'b00};
    end
    prev_hold = reset_n && imem_req && !imem_ack;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] old_addr;
    logic        bad;
    logic        found;
    int          base;

    n_checks = 0; n_errors = 0; n_consumed = 0;
    pending = 1'b0; wcnt = 0; force_lat = 0; max_lat = 3;
    prev_hold = 1'b0; prev_addr = 32'h0;
    exp_pc = RESET_PC;
    ovr[32'h3000] = 32'h3C01_1234;
    ovr[32'h3004] = 32'h0000_0000;
    ovr[32'h3008] = 32'hFC00_0000;

    // reset values
    reset_n = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("rst_id_valid", {31'b0, c_idv}, 32'd0);
    check("rst_id_instr", c_instr, 32'h0);
    check("rst_id_pc", c_pc, 32'h0);
    check("rst_id_class", {28'b0, c_cls}, 32'hF);
    check("rst_imem_req", {31'b0, c_req}, 32'd0);

    // zero-wait fetch, back-to-back addresses, class codes
    reset_n = 1'b1;
    exp_pc  = RESET_PC;
    step(1'b0, 32'h0, 1'b1);
    check("t1_addr0", c_addr, 32'h3000);
    check("t1_ack0", {31'b0, c_ack}, 32'd1);
    check("t1_idv_before", {31'b0, c_idv}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t1_addr1", c_addr, 32'h3004);
    check("t1_idv_after", {31'b0, c_idv}, 32'd1);
    check("t2_pc0", c_pc, 32'h3000);
    check("t2_cls_lui", {28'b0, c_cls}, 32'd6);
    step(1'b0, 32'h0, 1'b1);
    check("t1_addr2", c_addr, 32'h3008);
    check("t2_pc1", c_pc, 32'h3004);
    check("t2_cls_sll", {28'b0, c_cls}, 32'd9);
    step(1'b0, 32'h0, 1'b1);
    check("t2_pc2", c_pc, 32'h3008);
    check("t2_cls_illegal", {28'b0, c_cls}, 32'hF);

    // back-pressure: slot holds, skid fills, requests stop
    step(1'b0, 32'h0, 1'b0);
    held_pc = c_pc;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (c_req || !c_idv || c_pc != held_pc) bad = 1'b1;
    end
    check("t3_stall_hold", {31'b0, bad}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_drain0", c_pc, held_pc);
    step(1'b0, 32'h0, 1'b1);
    check("t3_drain1", c_pc, held_pc + 32'd4);

    // redirect while waiting on a slow read
    force_lat = 3;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (pending) break;
    end
    step(1'b1, 32'h3101, 1'b1);
    old_addr = c_addr;
    bad = 1'b0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (c_idv) bad = 1'b1;
      if (c_req && c_addr != old_addr) begin
        check("t4_new_addr", c_addr, 32'h3100);
        found = 1'b1;
        break;
      end
    end
    check("t4_found", {31'b0, found}, 32'd1);
    check("t4_idv_low", {31'b0, bad}, 32'd0);

    // redirect coinciding with the ack
    force_lat = 2;
    for (int i = 0; i < 20; i++) begin
      if (pending && wcnt == 0) break;
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b1, 32'h4000, 1'b1);
    check("t5_ack_seen", {31'b0, c_ack}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    check("t5_addr", c_addr, 32'h4000);
    check("t5_req", {31'b0, c_req}, 32'd1);
    check("t5_idv", {31'b0, c_idv}, 32'd0);

    // PC wrap at the top of the address space
    force_lat = 0;
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (c_req && c_ack && c_addr == 32'h0) found = 1'b1;
    end
    check("pc_wrap", {31'b0, found}, 32'd1);

    // randomized traffic
    force_lat = -1;
    base = n_consumed;
    for (int i = 0; i < 2000; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                        : 32'h3000 + $urandom_range(0, 1023);
      step(rv, rpc, $urandom_range(0, 3) != 0);
    end
    check("progress", {31'b0, (n_consumed - base) > 100}, 32'd1);

    // reset in the middle of an outstanding read
    force_lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (pending) break;
      step(1'b0, 32'h0, 1'b1);
    end
    reset_n = 1'b0;
    pending = 1'b0;
    prev_hold = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    check("mid_rst_req", {31'b0, c_req}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    reset_n   = 1'b1;
    exp_pc    = RESET_PC;
    force_lat = 0;
    step(1'b0, 32'h0, 1'b1);
    check("mid_rst_addr", c_addr, RESET_PC);
    check("mid_rst_req1", {31'b0, c_req}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'd4);
    check("perf_stall", perf_stall_cnt, 32'd3);
`endif
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
